// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared fetch-unit package: FSM state encoding,
// default NOP word and PC increment helper.
package imem_fetch_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_SQUASH = 2'd3;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    // Sequential PC; wraps naturally at 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_watchdog.sv
// fetch_watchdog: saturating wait counter with sticky timeout flag.
// Ports: clk, rst (sync, active-low), i_clear, i_enable, o_flag.
module fetch_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_flag
);

    localparam int RAW_W = $clog2(TIMEOUT + 1);
    localparam int CW    = (RAW_W > 8) ? RAW_W : 8;

    logic [CW-1:0] r_cnt;
    logic          r_flag;
    logic [CW-1:0] w_inc;
    logic [CW-1:0] w_max;
    logic [CW-1:0] w_limit;

    assign w_max   = '1;
    assign w_limit = CW'(TIMEOUT);
    // Saturate instead of wrapping so a long stall never re-arms.
    assign w_inc   = (r_cnt == w_max) ? w_max : r_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
        end else if (i_enable) begin
            r_cnt <= w_inc;
            if (w_inc >= w_limit) begin
                r_flag <= 1'b1;
            end
        end
    end

    assign o_flag = r_flag;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: single outstanding request,
// hold buffer for pipeline stalls, wrong-path squash, watchdog.
// Ports: clk, rst (sync, active-low), fetch_addr/redirect/pipe_stall
// from the PC stage; mem_req/mem_addr/mem_ack/mem_rdata to memory;
// instr/instr_valid/imem_stall to the fetch latch; err_timeout flag.
module imem_fetch_ctrl #(
    parameter logic [31:0] NOP_INSTR = imem_fetch_ctrl_pkg::NOP_INSTR_DEF,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_addr,
    input  logic        redirect,
    input  logic        pipe_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        imem_stall,
    output logic        err_timeout
);

    import imem_fetch_ctrl_pkg::*;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_hold;

    logic [1:0]  w_next_state;
    logic [31:0] w_next_addr;
    logic        w_capture;
    logic        w_valid;
    logic        w_use_hold;
    logic        w_release;
    logic        w_active;
    logic        w_wd_clear;
    logic        w_wd_flag;

    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_addr;
        w_capture    = 1'b0;
        w_valid      = 1'b0;
        w_use_hold   = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_next_state = ST_REQ;
                w_next_addr  = fetch_addr;
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (redirect) begin
                        w_release   = 1'b1;
                        w_next_addr = fetch_addr;
                    end else if (!pipe_stall) begin
                        w_valid     = 1'b1;
                        w_release   = 1'b1;
                        w_next_addr = next_pc(fetch_addr);
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = ST_HOLD;
                    end
                end else if (redirect) begin
                    // Request stays on the bus; its data is wrong-path.
                    w_next_state = ST_SQUASH;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    w_release    = 1'b1;
                    w_next_state = ST_REQ;
                    w_next_addr  = fetch_addr;
                end else if (!pipe_stall) begin
                    w_valid      = 1'b1;
                    w_use_hold   = 1'b1;
                    w_release    = 1'b1;
                    w_next_state = ST_REQ;
                    w_next_addr  = next_pc(fetch_addr);
                end
            end
            ST_SQUASH: begin
                // PC already points at the redirect target; keep it held.
                if (mem_ack) begin
                    w_next_state = ST_REQ;
                    w_next_addr  = fetch_addr;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_next_state;
            r_addr  <= w_next_addr;
            if (w_capture) begin
                r_hold <= mem_rdata;
            end
        end
    end

    assign w_active   = (r_state == ST_REQ) || (r_state == ST_SQUASH);
    assign w_wd_clear = (w_next_state != r_state) || mem_ack;

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_wd_clear),
        .i_enable (w_active),
        .o_flag   (w_wd_flag)
    );

    // Outputs are forced to reset values for the whole reset cycle,
    // not just after the sampling edge.
    assign mem_req     = rst && w_active;
    assign mem_addr    = rst ? r_addr : 32'd0;
    assign instr_valid = rst && w_valid;
    assign instr       = instr_valid ? (w_use_hold ? r_hold : mem_rdata)
                                     : NOP_INSTR;
    assign imem_stall  = !(rst && w_release);
    assign err_timeout = rst && w_wd_flag;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, timeout
// sequence and randomized traffic against a transaction model.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          TO  = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_addr;
    logic        redirect;
    logic        pipe_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        imem_stall;
    logic        err_timeout;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_addr  (fetch_addr),
        .redirect    (redirect),
        .pipe_stall  (pipe_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .imem_stall  (imem_stall),
        .err_timeout (err_timeout)
    );

    typedef struct {
        logic        rst;
        logic [31:0] fa;
        logic        rd;
        logic        ps;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_stall;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic [31:0] fa, input logic rd,
        input logic ps, input logic ack, input logic [31:0] rdata,
        input logic e_req, input logic [31:0] e_addr,
        input logic [31:0] e_instr, input logic e_valid,
        input logic e_stall
    );
        vec_t v;
        v.rst = r; v.fa = fa; v.rd = rd; v.ps = ps;
        v.ack = ack; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_valid = e_valid; v.e_stall = e_stall; v.e_err = 1'b0;
        return v;
    endfunction

    // Drive one cycle of inputs just after the edge, sample mid-cycle.
    task automatic step(
        input logic r, input logic [31:0] fa, input logic rd,
        input logic ps, input logic ack, input logic [31:0] rdata
    );
        @(posedge clk);
        #1;
        rst = r; fetch_addr = fa; redirect = rd;
        pipe_stall = ps; mem_ack = ack; mem_rdata = rdata;
        @(negedge clk);
    endtask

    task automatic check_all(
        input string tag, input int idx,
        input logic e_req, input logic [31:0] e_addr,
        input logic [31:0] e_instr, input logic e_valid,
        input logic e_stall, input logic e_err
    );
        n_vec++;
        if (mem_req !== e_req || mem_addr !== e_addr ||
            instr !== e_instr || instr_valid !== e_valid ||
            imem_stall !== e_stall || err_timeout !== e_err) begin
            n_bad++;
            $display("FAIL %s[%0d] got req=%b addr=%h instr=%h v=%b stall=%b err=%b want req=%b addr=%h instr=%h v=%b stall=%b err=%b",
                     tag, idx, mem_req, mem_addr, instr, instr_valid,
                     imem_stall, err_timeout, e_req, e_addr, e_instr,
                     e_valid, e_stall, e_err);
        end
    endtask

    task automatic check1(input string tag, input logic [31:0] got,
                          input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Transaction-level reference state.
    logic        m_started;
    logic        m_wrong;
    logic        m_held;
    logic [31:0] m_word;
    logic [31:0] m_addr;
    int          m_wait;
    logic        m_err;

    logic        x_req;
    logic [31:0] x_addr;
    logic [31:0] x_instr;
    logic        x_valid;
    logic        x_stall;
    logic        x_err;

    task automatic model(
        input logic r, input logic [31:0] fa, input logic rd,
        input logic ps, input logic ack, input logic [31:0] rdata
    );
        x_req = 0; x_addr = 0; x_instr = NOP;
        x_valid = 0; x_stall = 1; x_err = 0;
        if (!r) begin
            m_started = 0; m_wrong = 0; m_held = 0; m_word = 0;
            m_addr = 0; m_wait = 0; m_err = 0;
        end else if (!m_started) begin
            x_addr = m_addr; x_err = m_err;
            m_started = 1; m_addr = fa; m_wait = 0;
        end else if (m_held) begin
            x_addr = m_addr; x_err = m_err;
            if (rd) begin
                x_stall = 0; m_held = 0; m_addr = fa; m_wait = 0;
            end else if (!ps) begin
                x_valid = 1; x_instr = m_word; x_stall = 0;
                m_held = 0; m_addr = fa + 32'd4; m_wait = 0;
            end
        end else begin
            x_req = 1; x_addr = m_addr; x_err = m_err;
            if (ack) begin
                m_wait = 0;
                if (m_wrong) begin
                    m_wrong = 0; m_addr = fa;
                end else if (rd) begin
                    x_stall = 0; m_addr = fa;
                end else if (!ps) begin
                    x_valid = 1; x_instr = rdata; x_stall = 0;
                    m_addr = fa + 32'd4;
                end else begin
                    m_held = 1; m_word = rdata;
                end
            end else if (rd && !m_wrong) begin
                m_wrong = 1; m_wait = 0;
            end else begin
                if (m_wait < 255) m_wait++;
                if (m_wait >= TO) m_err = 1;
            end
        end
    endtask

    initial begin
        rst = 0; fetch_addr = 0; redirect = 0;
        pipe_stall = 0; mem_ack = 0; mem_rdata = 0;

        // rst fa rd ps ack rdata | req addr instr v stall
        tbl.push_back(mk(0, 32'h0,   0,0,0, 32'h0,        0, 32'h0,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h0,   0,0,0, 32'h0,        0, 32'h0,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h0,   0,0,0, 32'h0,        1, 32'h0,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h0,   0,0,0, 32'h0,        1, 32'h0,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h0,   0,0,1, 32'h00500093, 1, 32'h0,   32'h00500093, 1,0));
        tbl.push_back(mk(1, 32'h4,   0,0,0, 32'h0,        1, 32'h4,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h4,   0,1,1, 32'h11111111, 1, 32'h4,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h4,   0,1,0, 32'h0,        0, 32'h4,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h4,   0,1,0, 32'h0,        0, 32'h4,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h4,   0,0,0, 32'h0,        0, 32'h4,   32'h11111111, 1,0));
        tbl.push_back(mk(1, 32'h8,   1,0,0, 32'h0,        1, 32'h8,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h100, 0,0,0, 32'h0,        1, 32'h8,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h100, 0,0,1, 32'hDEADBEEF, 1, 32'h8,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h100, 0,0,0, 32'h0,        1, 32'h100, NOP,          0,1));
        tbl.push_back(mk(1, 32'h200, 1,0,1, 32'h22222222, 1, 32'h100, NOP,          0,0));
        tbl.push_back(mk(1, 32'h200, 0,0,0, 32'h0,        1, 32'h200, NOP,          0,1));
        tbl.push_back(mk(0, 32'h200, 0,0,1, 32'h66666666, 0, 32'h0,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h40,  0,0,1, 32'h33333333, 0, 32'h0,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h40,  0,0,0, 32'h0,        1, 32'h40,  NOP,          0,1));
        tbl.push_back(mk(1, 32'hFFFFFFFC, 0,0,1, 32'h44444444, 1, 32'h40, 32'h44444444, 1,0));
        tbl.push_back(mk(1, 32'h0,   0,0,0, 32'h0,        1, 32'h0,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h0,   0,1,1, 32'h55555555, 1, 32'h0,   NOP,          0,1));
        tbl.push_back(mk(1, 32'h300, 1,1,0, 32'h0,        0, 32'h0,   NOP,          0,0));
        tbl.push_back(mk(1, 32'h300, 0,0,0, 32'h0,        1, 32'h300, NOP,          0,1));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].fa, tbl[i].rd, tbl[i].ps,
                 tbl[i].ack, tbl[i].rdata);
            check_all("tbl", i, tbl[i].e_req, tbl[i].e_addr,
                      tbl[i].e_instr, tbl[i].e_valid,
                      tbl[i].e_stall, tbl[i].e_err);
        end

        // Watchdog: request left unanswered.
        step(0, 32'h80, 0,0,0, 32'h0);
        check1("wd_rst_err", {31'd0, err_timeout}, 32'd0);
        step(1, 32'h80, 0,0,0, 32'h0);
        for (int i = 1; i <= TO; i++) begin
            step(1, 32'h80, 0,0,0, 32'h0);
            if (i == TO) begin
                check1("wd_before_err", {31'd0, err_timeout}, 32'd0);
                check1("wd_req_held", {31'd0, mem_req}, 32'd1);
            end
        end
        step(1, 32'h80, 0,0,0, 32'h0);
        check1("wd_err_set", {31'd0, err_timeout}, 32'd1);
        step(1, 32'h80, 0,0,1, 32'hABCD0001);
        check1("wd_ack_valid", {31'd0, instr_valid}, 32'd1);
        check1("wd_ack_instr", instr, 32'hABCD0001);
        check1("wd_err_sticky", {31'd0, err_timeout}, 32'd1);
        step(1, 32'h84, 0,0,0, 32'h0);
        check1("wd_err_sticky2", {31'd0, err_timeout}, 32'd1);
        check1("wd_next_addr", mem_addr, 32'h84);
        step(0, 32'h84, 0,0,0, 32'h0);
        check1("wd_err_clr", {31'd0, err_timeout}, 32'd0);
        step(1, 32'h84, 0,0,0, 32'h0);
        check1("wd_err_after", {31'd0, err_timeout}, 32'd0);

        // Randomized traffic in segments of varying ack density.
        model(0, 0, 0, 0, 0, 0);
        step(0, 0, 0,0,0, 0);
        check_all("rnd", -1, x_req, x_addr, x_instr, x_valid,
                  x_stall, x_err);
        for (int seg = 0; seg < 8; seg++) begin
            int ack_pct;
            int rst_pct;
            ack_pct = (seg == 3) ? 0 : 20 + 10 * (seg % 5);
            rst_pct = (seg == 3) ? 0 : 1;
            for (int c = 0; c < 400; c++) begin
                logic        r;
                logic [31:0] fa;
                logic        rd;
                logic        ps;
                logic        ack;
                logic [31:0] rdata;
                r     = ($urandom_range(99) >= rst_pct);
                fa    = {$urandom, 2'b00} >> 0;
                fa    = (($urandom_range(9) == 0) ? 32'hFFFFFFFC
                                                   : {$urandom} & 32'hFFFF_FFFC);
                rd    = ($urandom_range(99) < 10);
                ps    = ($urandom_range(99) < 30);
                ack   = ($urandom_range(99) < ack_pct);
                rdata = $urandom;
                model(r, fa, rd, ps, ack, rdata);
                step(r, fa, rd, ps, ack, rdata);
                check_all("rnd", seg * 400 + c, x_req, x_addr, x_instr,
                          x_valid, x_stall, x_err);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the instruction word presented on instr while no valid fetch is delivered.
REQ-002 Parameter TIMEOUT, default 255, SHALL be the maximum REQ/SQUASH wait cycles before err_timeout asserts.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  in  1  SHALL be a synchronous, active-low reset (0 = reset).
REQ-005 fetch_addr  in  32  PC value to fetch.
REQ-006 redirect  in  1  jump taken this cycle; the in-flight fetch is wrong-path.
REQ-007 pipe_stall  in  1  data-cache stall; the downstream instruction latch is frozen.
REQ-008 mem_req  out  1  instruction memory request.
REQ-009 mem_addr  out  32  request address.
REQ-010 mem_ack  in  1  one-cycle response strobe; mem_rdata valid in the same cycle.
REQ-011 mem_rdata  in  32  fetched word.
REQ-012 instr  out  32  instruction to the fetch instruction latch.
REQ-013 instr_valid  out  1  instr holds a correct-path fetched word this cycle.
REQ-014 imem_stall  out  1  holds the PC; low only in the cycle a word is delivered or discarded on redirect.
REQ-015 err_timeout  out  1  sticky watchdog flag.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, HOLD, SQUASH.
REQ-017 IDLE SHALL last exactly one cycle after reset deassertion, then go to REQ, latching mem_addr <= fetch_addr.
REQ-018 Bus rule: while mem_req=1, mem_addr SHALL stay stable; a request SHALL never be withdrawn before mem_ack.
REQ-019 REQ, mem_ack=1, redirect=0, pipe_stall=0: instr=mem_rdata, instr_valid=1, imem_stall=0 in that cycle; stay in REQ, mem_addr <= fetch_addr+4.
REQ-020 REQ, mem_ack=1, redirect=0, pipe_stall=1: capture mem_rdata into hold_reg; go to HOLD; mem_req=0 while in HOLD.
REQ-021 HOLD with pipe_stall=0: instr=hold_reg, instr_valid=1, imem_stall=0; go to REQ with mem_addr <= fetch_addr+4.
REQ-022 REQ, mem_ack=0, redirect=1: go to SQUASH; mem_req stays 1 with the old mem_addr.
REQ-023 SQUASH: on mem_ack, discard mem_rdata, instr_valid=0, go to REQ with mem_addr <= fetch_addr (redirected PC).
REQ-024 redirect and mem_ack in the same REQ cycle: discard the data, instr_valid=0, imem_stall=0, go to REQ with mem_addr <= fetch_addr.
REQ-025 redirect in HOLD: discard hold_reg, go to REQ with mem_addr <= fetch_addr; redirect has priority over pipe_stall.
REQ-026 In every cycle with instr_valid=0, instr SHALL equal NOP_INSTR.
REQ-027 Watchdog: an 8-bit or wider counter SHALL clear on state entry and on mem_ack, and increment each REQ/SQUASH cycle; err_timeout SHALL set when the count reaches TIMEOUT and hold until reset; the counter SHALL saturate and not wrap.
REQ-028 fetch_addr+4 SHALL be computed modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Reset
REQ-029 While rst=0: state=IDLE, mem_req=0, mem_addr=0, instr=NOP_INSTR, instr_valid=0, imem_stall=1, hold_reg=0, watchdog=0, err_timeout=0.
REQ-030 Reset mid-request SHALL abandon the transaction; any mem_ack arriving in IDLE SHALL be ignored.

Structure
REQ-031 The FSM state encoding and NOP_INSTR value SHALL live in the shared processor package.
REQ-032 The watchdog SHALL be one sub-module, fetch_watchdog (clear, enable, saturate, sticky flag); all else is flat.

Verification
REQ-033 Reset, then fetch_addr=0, ack after 2 cycles with 32'h00500093 -> mem_req=1, mem_addr=0, then instr=32'h00500093, instr_valid=1, imem_stall=0 for one cycle; next mem_addr=4.
REQ-034 Ack while pipe_stall=1 for 3 cycles -> HOLD, mem_req=0, instr=NOP; delivered in the first cycle pipe_stall=0.
REQ-035 redirect with no ack, fetch_addr=32'h100 -> mem_addr unchanged until ack, data discarded, then mem_addr=32'h100.
REQ-036 redirect coincident with ack -> instr_valid=0, instr=NOP, next mem_addr=fetch_addr.
REQ-037 No ack for TIMEOUT cycles -> err_timeout=1, stays 1 after ack, clears only on rst=0.
REQ-038 rst=0 for one cycle during REQ, with ack in the following IDLE cycle -> all outputs at REQ-029 values and the ack ignored.
